// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 frame constants and scan-code type for the receiver and downstream decoders
package ps2_pkg;
    localparam int   PS2_FRAME_BITS = 11;
    localparam logic PS2_START      = 1'b0;
    localparam logic PS2_STOP       = 1'b1;
    typedef logic [7:0] scan_code_t;
endpackage

// File: rtl/ps2_sync_fifo.sv
// ps2_sync_fifo: small FIFO with registered head/valid, drop flag when pushed while full without a pop
module ps2_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_valid,
    output logic             o_drop
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr, r_rd;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_rdata;
    logic             r_valid;
    logic             w_full, w_pop, w_push;
    logic [CW-1:0]    w_count_nxt, w_left;
    logic [AW-1:0]    w_rd_nxt;
    assign w_full      = r_count == CW'(DEPTH);
    assign w_pop       = r_valid & i_pop;
    assign w_push      = i_push & (~w_full | w_pop);
    assign o_drop      = i_push & w_full & ~w_pop;
    assign w_left      = r_count - CW'(w_pop);
    assign w_count_nxt = w_left + CW'(w_push);
    assign w_rd_nxt    = r_rd + AW'(w_pop);
    assign o_rdata     = r_rdata;
    assign o_valid     = r_valid;
    // storage write; the head is registered separately so a same-cycle overwrite of the popped slot is safe
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_wdata;
    end
    // pointers, occupancy and the registered head (zero when empty, incoming byte when it becomes the head)
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_rdata <= '0;
            r_valid <= 1'b0;
        end else begin
            r_wr    <= r_wr + AW'(w_push);
            r_rd    <= w_rd_nxt;
            r_count <= w_count_nxt;
            r_valid <= w_count_nxt != '0;
            r_rdata <= (w_count_nxt == '0) ? '0 : (w_left == '0) ? i_wdata : r_mem[w_rd_nxt];
        end
    end
endmodule

// File: rtl/ps2_scan_receiver.sv
// ps2_scan_receiver: synchronize PS/2 pins, deserialize and validate frames, buffer good bytes in a FIFO
module ps2_scan_receiver
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       ready,
    input  logic       clr_flags,
    output logic [7:0] data,
    output logic       valid,
    output logic       overflow,
    output logic       frame_err
);
    localparam int BW = $clog2(PS2_FRAME_BITS);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(PS2_FRAME_BITS - 1);
    logic [2:0]                  r_clk_sync;
    logic [1:0]                  r_dat_sync;
    logic [BW-1:0]               r_bit_cnt;
    logic [PS2_FRAME_BITS-2:0]   r_shift;
    logic [TW-1:0]               r_idle;
    logic                        r_overflow, r_frame_err;
    logic                        w_strobe, w_bit, w_last, w_good, w_push, w_timeout, w_drop;
    logic [PS2_FRAME_BITS-1:0]   w_frame;
    scan_code_t                  w_byte;
    assign w_strobe  = r_clk_sync[2] & ~r_clk_sync[1];
    assign w_bit     = r_dat_sync[1];
    assign w_frame   = {w_bit, r_shift};
    assign w_byte    = w_frame[8:1];
    assign w_last    = w_strobe && r_bit_cnt == LAST_BIT;
    assign w_good    = w_frame[0] == PS2_START && w_frame[10] == PS2_STOP && ^w_frame[9:1];
    assign w_push    = w_last & w_good;
    assign w_timeout = r_bit_cnt != '0 && !w_strobe && r_idle == TW'(TIMEOUT_CYCLES - 1);
    assign overflow  = r_overflow;
    assign frame_err = r_frame_err;
    // pin synchronizers, idle-high so reset never fakes a falling edge
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_clk_sync <= '1;
            r_dat_sync <= '1;
        end else begin
            r_clk_sync <= {r_clk_sync[1:0], ps2_clk};
            r_dat_sync <= {r_dat_sync[0], ps2_data};
        end
    end
    // shift bits in LSB first on each falling-edge strobe; the final bit is taken straight from the pin
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else if (w_timeout) begin
            r_bit_cnt <= '0;
        end else if (w_strobe) begin
            r_shift   <= {w_bit, r_shift[PS2_FRAME_BITS-2:1]};
            r_bit_cnt <= w_last ? '0 : r_bit_cnt + 1'b1;
        end
    end
    // mid-frame idle watchdog
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_idle <= '0;
        else         r_idle <= (w_strobe || r_bit_cnt == '0 || w_timeout) ? '0 : r_idle + 1'b1;
    end
    // error pulse and sticky overflow (a new drop wins over a clear)
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_frame_err <= (w_last & ~w_good) | w_timeout;
            r_overflow  <= w_drop | (r_overflow & ~clr_flags);
        end
    end
    ps2_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(scan_code_t))) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_push  (w_push),
        .i_pop   (ready),
        .i_wdata (w_byte),
        .o_rdata (data),
        .o_valid (valid),
        .o_drop  (w_drop)
    );
endmodule

// File: tb/tb_ps2_scan_receiver.sv
// tb_ps2_scan_receiver: randomized PS/2 frames against a queue-based reference model
module tb_ps2_scan_receiver;
    localparam int DEPTH = 8;
    localparam int TMO   = 400;
    localparam int H     = 20;
    logic       clk = 0;
    logic       resetn = 0;
    logic       ps2_clk = 1;
    logic       ps2_data = 1;
    logic       ready = 0;
    logic       clr_flags = 0;
    logic [7:0] data;
    logic       valid, overflow, frame_err;
    int         n_checks = 0;
    int         n_errors = 0;
    int         ready_mode = 0;
    int         err_seen = 0;
    int         exp_err = 0;
    int         valid_cycles = 0;
    int         pops = 0;
    logic       exp_ovf = 0;
    logic [7:0] q[$];

    ps2_scan_receiver #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .ready(ready), .clr_flags(clr_flags), .data(data), .valid(valid),
        .overflow(overflow), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // reference: a frame is good iff start=0, stop=1, odd parity; good bytes queue up to DEPTH
    task automatic model_frame(input logic [7:0] b, input bit good);
        if (!good) exp_err++;
        else if (q.size() < DEPTH) q.push_back(b);
        else exp_ovf = 1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            tick(H);
            ps2_clk = 0;
            if (i == 10) model_frame(b, !bad_par && !bad_stop);
            tick(H);
            ps2_clk = 1;
        end
        ps2_data = 1;
        tick(2 * H);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (q.size() == 0 && !valid) break;
        end
        check(tag, q.size(), 0);
        check({tag, "_valid"}, valid, 0);
    endtask

    always begin
        @(posedge clk);
        #1;
        ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : ready_mode[0];
    end

    always @(negedge clk) begin
        if (resetn) begin
            if (frame_err) err_seen++;
            if (valid) valid_cycles++;
            if (!valid) check("data_idle", data, 0);
            if (valid && ready) begin
                pops++;
                if (q.size() == 0) check("pop_unexpected", data, 32'hFFFF_FFFF);
                else check("data", data, q.pop_front());
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, p0;
        logic [7:0] b;
        int r;
        tick(5);
        @(negedge clk);
        check("rst_data", data, 0);
        check("rst_valid", valid, 0);
        check("rst_ovf", overflow, 0);
        check("rst_ferr", frame_err, 0);
        resetn = 1;
        tick(5);

        ready_mode = 1;
        tick(3);
        valid_cycles = 0;
        send_frame(8'h1C, 0, 0, 11);
        wait_drain("t1_drain");
        check("t1_valid_cycles", valid_cycles, 1);
        check("t1_ferr", err_seen, 0);

        ready_mode = 0;
        tick(3);
        send_frame(8'hF0, 0, 0, 11);
        send_frame(8'h1C, 0, 0, 11);
        @(negedge clk);
        check("t2_hold_valid", valid, 1);
        check("t2_hold_data", data, 8'hF0);
        ready_mode = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ready) break;
        end
        check("t2_first", data, 8'hF0);
        @(negedge clk);
        check("t2_second_valid", valid, 1);
        check("t2_second", data, 8'h1C);
        @(negedge clk);
        check("t2_empty", valid, 0);

        e0 = err_seen;
        send_frame(8'h1C, 1, 0, 11);
        tick(5);
        check("t3_parity_err", err_seen, e0 + 1);
        check("t3_parity_valid", valid, 0);
        send_frame(8'h1C, 0, 1, 11);
        tick(5);
        check("t3_stop_err", err_seen, e0 + 2);
        check("t3_stop_valid", valid, 0);

        ready_mode = 0;
        tick(3);
        p0 = pops;
        for (int i = 0; i < 9; i++) begin
            if (i == 8) check("t4_ovf_before", overflow, 0);
            send_frame(8'($urandom), 0, 0, 11);
        end
        check("t4_ovf_set", overflow, exp_ovf);
        check("t4_ovf_one", overflow, 1);
        clr_flags = 1;
        tick(1);
        clr_flags = 0;
        exp_ovf = 0;
        @(negedge clk);
        check("t4_ovf_clr", overflow, 0);
        ready_mode = 1;
        wait_drain("t4_drain");
        check("t4_pops", pops - p0, DEPTH);

        e0 = err_seen;
        send_frame(8'h77, 0, 0, 5);
        tick(TMO + 20);
        exp_err++;
        check("t5_timeout", err_seen, e0 + 1);
        check("t5_valid", valid, 0);
        send_frame(8'h29, 0, 0, 11);
        wait_drain("t5_drain");

        e0 = err_seen;
        send_frame(8'h3A, 0, 0, 7);
        resetn = 0;
        tick(3);
        @(negedge clk);
        check("t6_rst_data", data, 0);
        check("t6_rst_valid", valid, 0);
        check("t6_rst_ovf", overflow, 0);
        check("t6_rst_ferr", frame_err, 0);
        resetn = 1;
        tick(50);
        check("t6_no_push", valid, 0);
        check("t6_no_err", err_seen, e0);
        send_frame(8'h5A, 0, 0, 11);
        wait_drain("t6_drain");

        ready_mode = 2;
        for (int i = 0; i < 20; i++) begin
            b = 8'($urandom);
            r = $urandom_range(0, 9);
            send_frame(b, r == 0, r == 1, 11);
        end
        ready_mode = 1;
        wait_drain("rand_drain");
        check("rand_errs", err_seen, exp_err);
        check("rand_ovf", overflow, exp_ovf);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
